// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one fullAdder cell.
// Operands are captured on an accepted start and consumed LSB first, one bit
// per clock, with the carry held in a flop between bits. {Cout,S} = A+B+Cin.
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the registered Ovf output
// (two's-complement signed overflow of the completed addition).
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, sampled only while idle
//   A, B   WIDTH-bit operands, captured on accepted start
//   Cin    carry-in, captured on accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse, S/Cout (and Ovf) valid
//   S      registered WIDTH-bit sum, held until next completion or reset
//   Cout   registered final carry-out
//   Ovf    registered signed overflow (SERIAL_ADD_OVF_EN only)
//
// Timing: start sampled at edge N -> busy after edges N+1..N+WIDTH -> done after
// edge N+WIDTH+1. busy/done are registered decodes of the state, so they trail
// the state by one cycle; S/Cout load on the RUN->DONE transition.

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
  output logic             Cout,
  output logic             Ovf
`else
  output logic             Cout
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SUM_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  // Only WIDTH-1 partial bits need storing; the final bit comes straight from the cell.
  logic [SUM_W-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   sum_full_c;
  logic               last_bit_c;

  logic               busy_n;
  logic               done_n;
  logic               load_c;
  logic               step_c;
  logic               finish_c;

  // Single shared full-adder cell.
  fullAdder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Sum including the bit being produced this cycle.
  assign sum_full_c = {fa_s, sum_sh};
  assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_n  = state;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy_n = 1'b1;
        step_c = 1'b1;
        if (last_bit_c) begin
          finish_c = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, carry flop, counter, result and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      Cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      Ovf    <= 1'b0;
`endif
    end else begin
      busy <= busy_n;
      done <= done_n;
      if (load_c) begin
        a_sh  <= A;
        b_sh  <= B;
        carry <= Cin;
        cnt   <= '0;
      end
      if (step_c) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_full_c[WIDTH-1:1];
        carry  <= fa_cout;
        cnt    <= cnt + CNT_W'(1);
      end
      if (finish_c) begin
        S    <= sum_full_c;
        Cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
        // carry still holds the carry into the MSB during the final bit.
        Ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule

// fullAdder: single-bit full adder cell.
// Ports: A, B, Cin inputs; S sum, Cout carry-out.
module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed cases plus randomized
// operations checked against an arithmetic reference model.
// Define SERIAL_ADD_OVF_EN to also check the Ovf output.

module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int nvec;
  int nerr;

  // Expected held result (reference model state).
  logic [W-1:0] exp_s;
  logic         exp_cout;
  logic         exp_ovf;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .S     (s),
`ifdef SERIAL_ADD_OVF_EN
    .Cout  (cout),
    .Ovf   (ovf)
`else
    .Cout  (cout)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       output logic [W-1:0] ms, output logic mco, output logic mov);
    int unsigned u;
    int          sa;
    int          sb;
    int          t;
    u   = int'(ma) + int'(mb) + int'(mc);
    ms  = W'(u % (1 << W));
    mco = (u >= (1 << W));
    sa  = (ma >= (1 << (W - 1))) ? int'(ma) - (1 << W) : int'(ma);
    sb  = (mb >= (1 << (W - 1))) ? int'(mb) - (1 << W) : int'(mb);
    t   = sa + sb + int'(mc);
    mov = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_s"}, 64'(s), 64'(exp_s));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
  endtask

  // One full operation; optionally injects an ignored start at busy cycle inj_at.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        input int inj_at);
    logic [W-1:0] ms;
    logic         mco;
    logic         mov;
    model(oa, ob, oc, ms, mco, mov);
    @(negedge clk);
    start = 1'b1; a = oa; b = ob; cin = oc;
    @(negedge clk);
    // Operands are captured; scramble inputs to prove they are not re-read.
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 1; i <= int'(W); i++) begin
      @(negedge clk);
      check("busy_run", 64'(busy), 64'd1);
      check("done_run", 64'(done), 64'd0);
      if (i < int'(W)) check_hold("hold_run");
      start = (i == inj_at);
      if (i == inj_at) begin
        a = 8'hAA; b = 8'h55;
      end
    end
    start = 1'b0;
    exp_s = ms; exp_cout = mco;
`ifdef SERIAL_ADD_OVF_EN
    exp_ovf = mov;
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check_hold("result");
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", 64'(ovf), 64'(exp_ovf));
`endif
    @(negedge clk);
    check("done_once", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check_hold("hold_idle");
  endtask

  initial begin
    int done_cnt;
    int last_done;
    nvec = 0; nerr = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    exp_s = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_hold("rst");
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    repeat (4) begin
      @(negedge clk);
      check_hold("idle_hold");
    end
    // start during RUN is ignored.
    run_op(8'h10, 8'h20, 1'b0, 3);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_s = '0; exp_cout = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check_hold("abort");
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_op(8'h0F, 8'h01, 1'b0, 0);

    // start held high: one result every W+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;
    done_cnt = 0; last_done = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (done) begin
        check("cont_s", 64'(s), 64'h03);
        if (done_cnt > 0) check("cont_period", 64'(j - last_done), 64'(W + 2));
        done_cnt++;
        last_done = j;
      end
      if (j == 30) rst = 1'b1;
    end
    check("cont_count", 64'(done_cnt), 64'd3);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_start_nocap", 64'(busy), 64'd0);
    exp_s = '0; exp_cout = 1'b0;
    check_hold("rst_start");

    // Overflow corner cases (sums checked in all builds).
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);

    // Randomized operations against the model.
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
